// File: rtl/skinny_ctrl.sv
// Round-sequencing controller for an iterated SKINNY-128-384+ datapath: loads a block,
// steps NUMRND rounds per cycle, then holds the ciphertext. Optional abort: SKINNY_CTRL_ABORT_EN.
module skinny_ctrl #(
    parameter int NUMRND  = 2,
    parameter int NROUNDS = 40
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  ready,
    input  logic [127:0]          din_state,
    input  logic [127:0]          din_key,
    input  logic [127:0]          din_tweak,
    input  logic [127:0]          din_cnt,
    output logic [127:0]          dout,
    output logic                  dout_valid,
    input  logic                  dout_ack,
    output logic [127:0]          roundstate,
    output logic [127:0]          roundkey,
    output logic [127:0]          roundtweak,
    output logic [127:0]          roundcnt,
    output logic [6*NUMRND-1:0]   constant,
    input  logic [127:0]          nextstate,
    input  logic [127:0]          nextkey,
    input  logic [127:0]          nexttweak,
    input  logic [127:0]          nextcnt
`ifdef SKINNY_CTRL_ABORT_EN
    ,
    input  logic                  abort
`endif
);

    // state | meaning
    // IDLE  | waiting for start, ready high
    // RUN   | datapath iterating, NUMRND rounds per edge
    // DONE  | ciphertext presented until dout_ack

    localparam int NCYC = NROUNDS / NUMRND;
    localparam int CNTW = (NCYC > 1) ? $clog2(NCYC) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t            fsm;
    fsm_t            fsm_nxt;

    logic [127:0]    reg_state;
    logic [127:0]    reg_key;
    logic [127:0]    reg_tweak;
    logic [127:0]    reg_cnt;
    logic [5:0]      rc;
    logic [CNTW-1:0] rnd_cnt;
    logic [5:0]      rc_chain [0:NUMRND];
    logic            last_cyc;
    logic            abort_req;
    logic            abort_clr;

    function automatic logic [5:0] lfsr_step(input logic [5:0] v);
        return {v[4:0], v[5] ^ v[4] ^ 1'b1};
    endfunction

`ifdef SKINNY_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Abort only matters once a block is in flight; in IDLE it merely vetoes start.
    assign abort_clr = abort_req && (fsm != IDLE);
    assign last_cyc  = (rnd_cnt == CNTW'(NCYC - 1));

    assign rc_chain[0] = rc;
    for (genvar g = 0; g < NUMRND; g++) begin : g_rc
        assign rc_chain[g+1]       = lfsr_step(rc_chain[g]);
        assign constant[6*g +: 6]  = rc_chain[g];
    end

    assign roundstate = reg_state;
    assign roundkey   = reg_key;
    assign roundtweak = reg_tweak;
    assign roundcnt   = reg_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE: begin
                if (start && !abort_req) begin
                    fsm_nxt = RUN;
                end
            end
            RUN: begin
                if (abort_req) begin
                    fsm_nxt = IDLE;
                end else if (last_cyc) begin
                    fsm_nxt = DONE;
                end
            end
            DONE: begin
                if (abort_req || dout_ack) begin
                    fsm_nxt = IDLE;
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready      = 1'b0;
        dout_valid = 1'b0;
        dout       = '0;
        case (fsm)
            IDLE: ready = 1'b1;
            DONE: begin
                dout_valid = 1'b1;
                dout       = reg_state;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || abort_clr) begin
            reg_state <= '0;
            reg_key   <= '0;
            reg_tweak <= '0;
            reg_cnt   <= '0;
            rc        <= 6'h01;
            rnd_cnt   <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (start && !abort_req) begin
                        reg_state <= din_state;
                        reg_key   <= din_key;
                        reg_tweak <= din_tweak;
                        reg_cnt   <= din_cnt;
                        rc        <= 6'h01;
                        rnd_cnt   <= '0;
                    end
                end
                RUN: begin
                    reg_state <= nextstate;
                    reg_key   <= nextkey;
                    reg_tweak <= nexttweak;
                    reg_cnt   <= nextcnt;
                    rc        <= rc_chain[NUMRND];
                    rnd_cnt   <= rnd_cnt + CNTW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_skinny_ctrl.sv
// Bench for skinny_ctrl: a surrogate round datapath closes the loop, and a block-level
// model (spec round-constant sequence + iterated surrogate) predicts every ciphertext.
module tb_skinny_ctrl;

    localparam int NUMRND  = 2;
    localparam int NROUNDS = 40;
    localparam int NCYC    = NROUNDS / NUMRND;
    localparam int CW      = 6 * NUMRND;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           ready;
    logic [127:0]   din_state, din_key, din_tweak, din_cnt;
    logic [127:0]   dout;
    logic           dout_valid;
    logic           dout_ack;
    logic [127:0]   roundstate, roundkey, roundtweak, roundcnt;
    logic [CW-1:0]  constant;
    logic [127:0]   nextstate, nextkey, nexttweak, nextcnt;
`ifdef SKINNY_CTRL_ABORT_EN
    logic           abort;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    skinny_ctrl #(.NUMRND(NUMRND), .NROUNDS(NROUNDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ready      (ready),
        .din_state  (din_state),
        .din_key    (din_key),
        .din_tweak  (din_tweak),
        .din_cnt    (din_cnt),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ack   (dout_ack),
        .roundstate (roundstate),
        .roundkey   (roundkey),
        .roundtweak (roundtweak),
        .roundcnt   (roundcnt),
        .constant   (constant),
        .nextstate  (nextstate),
        .nextkey    (nextkey),
        .nexttweak  (nexttweak),
        .nextcnt    (nextcnt)
`ifdef SKINNY_CTRL_ABORT_EN
        ,
        .abort      (abort)
`endif
    );

    // Surrogate datapath: every register and the round constant feed the next state.
    function automatic logic [127:0] f_state(input logic [127:0] s, k, t, c, input logic [CW-1:0] cst);
        return {s[120:0], s[127:121]} ^ k ^ (t >> 3) ^ c ^ {cst, {(128-CW){1'b0}}} ^ 128'(cst);
    endfunction
    function automatic logic [127:0] f_key(input logic [127:0] k);
        return {k[126:0], k[127] ^ k[0]} ^ 128'h5;
    endfunction
    function automatic logic [127:0] f_tweak(input logic [127:0] t);
        return t + 128'h1_0000_0001;
    endfunction
    function automatic logic [127:0] f_cnt(input logic [127:0] c);
        return ~{c[63:0], c[127:64]};
    endfunction

    assign nextstate = f_state(roundstate, roundkey, roundtweak, roundcnt, constant);
    assign nextkey   = f_key(roundkey);
    assign nexttweak = f_tweak(roundtweak);
    assign nextcnt   = f_cnt(roundcnt);

    // Whole-block model: list all NROUNDS constants, then consume NUMRND per cycle.
    function automatic logic [127:0] ref_cipher(input logic [127:0] s0, k0, t0, c0);
        logic [5:0]    rcs [0:NROUNDS];
        logic [127:0]  s, k, t, c, ns;
        logic [CW-1:0] cst;
        rcs[0] = 6'h01;
        for (int r = 0; r < NROUNDS; r++)
            rcs[r+1] = {rcs[r][4:0], ~(rcs[r][5] ^ rcs[r][4])};
        s = s0; k = k0; t = t0; c = c0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            for (int i = 0; i < NUMRND; i++)
                cst[6*i +: 6] = rcs[cyc*NUMRND + i];
            ns = f_state(s, k, t, c, cst);
            k  = f_key(k);
            t  = f_tweak(t);
            c  = f_cnt(c);
            s  = ns;
        end
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_random(output logic [127:0] e);
        din_state = rand128();
        din_key   = rand128();
        din_tweak = rand128();
        din_cnt   = rand128();
        e = ref_cipher(din_state, din_key, din_tweak, din_cnt);
    endtask

    // Full block with ack held low for `hold` extra cycles in DONE.
    task automatic do_block(input string tag, input int hold);
        logic [127:0] e;
        int           l;
        chk({tag, "_ready_pre"}, 128'(ready), 128'(1));
        load_random(e);
        dout_ack = 1'b0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        l = 0;
        while (!dout_valid && l < 100) begin
            tick();
            l++;
        end
        chk({tag, "_lat"}, 128'(l), 128'(NCYC));
        chk({tag, "_dout"}, dout, e);
        repeat (hold) tick();
        chk({tag, "_hold"}, dout, e);
        dout_ack = 1'b1;
        tick();
        dout_ack = 1'b0;
        chk({tag, "_idle"}, 128'(ready), 128'(1));
    endtask

    logic [127:0] exp_a;
    logic [CW-1:0] exp_c;
    int           lat;
    logic         seen;

    initial begin
        rst = 1'b1; start = 1'b0; dout_ack = 1'b0;
        din_state = '0; din_key = '0; din_tweak = '0; din_cnt = '0;
`ifdef SKINNY_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) tick();
        exp_c = {6'h03, 6'h01};
        chk("rst_ready", 128'(ready), 128'(1));
        chk("rst_valid", 128'(dout_valid), 128'(0));
        chk("rst_dout", dout, 128'(0));
        chk("rst_rstate", roundstate, 128'(0));
        chk("rst_const", 128'(constant), 128'(exp_c));
        rst = 1'b0;
        tick();

        // Single block, ack tied high, with constant trace
        dout_ack = 1'b1;
        load_random(exp_a);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("a_ready_run", 128'(ready), 128'(0));
        chk("a_loaded", roundstate, din_state);
        chk("a_const0", 128'(constant), 128'(exp_c));
        tick();
        exp_c = {6'h0F, 6'h07};
        chk("a_const1", 128'(constant), 128'(exp_c));
        tick();
        exp_c = {6'h3E, 6'h1F};
        chk("a_const2", 128'(constant), 128'(exp_c));
        lat = 2;
        while (!dout_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("a_lat", 128'(lat), 128'(NCYC));
        chk("a_dout", dout, exp_a);
        tick();
        chk("a_valid_1cyc", 128'(dout_valid), 128'(0));
        chk("a_dout_zero", dout, 128'(0));
        chk("a_ready_after", 128'(ready), 128'(1));
        dout_ack = 1'b0;

        // Backpressure: 7 DONE cycles with ack low
        load_random(exp_a);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!dout_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("bp_lat", 128'(lat), 128'(NCYC));
        seen = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (!(dout_valid === 1'b1 && dout === exp_a && ready === 1'b0)) seen = 1'b0;
            if (i < 6) tick();
        end
        chk("bp_stable", 128'(seen), 128'(1));
        chk("bp_dout", dout, exp_a);
        dout_ack = 1'b1;
        tick();
        dout_ack = 1'b0;
        chk("bp_idle_ready", 128'(ready), 128'(1));
        chk("bp_idle_valid", 128'(dout_valid), 128'(0));

        // Busy starts at RUN cycles 5 and 19, then start+ack together in DONE
        load_random(exp_a);
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b1;
        for (int e = 1; e <= NCYC; e++) begin
            tick();
            start = 1'b0;
            if (e < NCYC && ready !== 1'b0) seen = 1'b0;
            if (e == 5 || e == 19) begin
                din_state = rand128(); din_key = rand128();
                din_tweak = rand128(); din_cnt = rand128();
                start = 1'b1;
            end
        end
        chk("busy_ready_low", 128'(seen), 128'(1));
        chk("busy_valid", 128'(dout_valid), 128'(1));
        chk("busy_dout", dout, exp_a);
        chk("busy_done_ready", 128'(ready), 128'(0));
        din_state = rand128();
        start = 1'b1; dout_ack = 1'b1;
        tick();
        start = 1'b0; dout_ack = 1'b0;
        chk("sa_ready", 128'(ready), 128'(1));
        chk("sa_valid", 128'(dout_valid), 128'(0));
        tick();
        chk("sa_not_started", 128'(ready), 128'(1));

        // Reset at RUN cycle 10
        load_random(exp_a);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_c = {6'h03, 6'h01};
        chk("mr_ready", 128'(ready), 128'(1));
        chk("mr_valid", 128'(dout_valid), 128'(0));
        chk("mr_const", 128'(constant), 128'(exp_c));
        chk("mr_rstate", roundstate, 128'(0));
        seen = 1'b0;
        repeat (25) begin
            tick();
            if (dout_valid !== 1'b0) seen = 1'b1;
        end
        chk("mr_no_valid", 128'(seen), 128'(0));
        do_block("mr_new", 0);

        // Reset wins over start
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        tick();
        chk("rs_start_ignored", 128'(ready), 128'(1));

        for (int b = 0; b < 5; b++)
            do_block($sformatf("rnd%0d", b), int'($urandom_range(0, 4)));

`ifdef SKINNY_CTRL_ABORT_EN
        // Abort at RUN cycle 3
        load_random(exp_a);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_ready", 128'(ready), 128'(1));
        chk("ab_rstate", roundstate, 128'(0));
        exp_c = {6'h03, 6'h01};
        chk("ab_const", 128'(constant), 128'(exp_c));
        seen = 1'b0;
        repeat (25) begin
            tick();
            if (dout_valid !== 1'b0) seen = 1'b1;
        end
        chk("ab_no_valid", 128'(seen), 128'(0));
        din_state = rand128();
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("ab_idle_reject", 128'(ready), 128'(1));
        chk("ab_idle_noload", roundstate, 128'(0));
        // Abort while holding in DONE
        load_random(exp_a);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (NCYC) tick();
        chk("abd_valid", 128'(dout_valid), 128'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abd_ready", 128'(ready), 128'(1));
        chk("abd_dout", dout, 128'(0));
        do_block("ab_b2b0", 0);
        do_block("ab_b2b1", 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
